// File: rtl/ssf_in_feeder.sv
// ssf input feeder: two per-port sample FIFOs served to ssf io_in on req_in.
// Optional: SSF_FEED_HOLD_EN makes an empty-port read return that port's last pop.
//
// Ports:
//   clk, rst (async active-low)
//   s_data/s_port/s_valid/s_ready : upstream push, s_port selects the FIFO
//   req_in  : one-hot read strobe (bit k = port k), 2'b11 is served as port 0
//   io_in   : combinational read data in the strobe cycle, else last delivered
//   level0/level1 : FIFO occupancy, 0..DEPTH
//   underflow/req_err : sticky flags, clr clears them synchronously
module ssf_in_feeder #(
  parameter int NUBITS = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_port,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        req_in,
  output logic [NUBITS-1:0] io_in,
  output logic [AW:0]       level0,
  output logic [AW:0]       level1,
  output logic              underflow,
  output logic              req_err,
  input  logic              clr
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        pop_ok;
  logic [1:0]        nonempty;
  logic [NUBITS-1:0] last_q;
  logic              uf_ev;
  logic              re_ev;

  // 2'b11 is treated as a port-0 read; port 1 only pops on a clean 2'b10
  assign pop      = {req_in == 2'b10, req_in[0]};
  assign nonempty = {level1 != '0, level0 != '0};
  assign pop_ok   = pop & nonempty;
  assign uf_ev    = |(pop & ~nonempty);
  assign re_ev    = req_in == 2'b11;

  // s_ready looks at registered level only: no same-cycle pop bypass
  assign s_ready = (s_port ? level1 : level0) != FULL;
  assign push[0] = s_valid & s_ready & ~s_port;
  assign push[1] = s_valid & s_ready & s_port;

  for (genvar k = 0; k < 2; k++) begin : g_port
    logic [NUBITS-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [AW:0]       lvl;
    logic [NUBITS-1:0] head;
    logic [NUBITS-1:0] uf_val;
    logic [NUBITS-1:0] rd_val;

    assign head   = mem[rp];
    assign rd_val = nonempty[k] ? head : uf_val;

    always_ff @(posedge clk) begin
      if (push[k]) mem[wp] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wp  <= '0;
        rp  <= '0;
        lvl <= '0;
      end else begin
        if (push[k])   wp <= wp + 1'b1;
        if (pop_ok[k]) rp <= rp + 1'b1;
        lvl <= lvl + (AW+1)'(push[k])
                   - (AW+1)'(pop_ok[k]);
      end
    end

`ifdef SSF_FEED_HOLD_EN
    logic [NUBITS-1:0] hold;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)           hold <= '0;
      else if (pop_ok[k]) hold <= head;
    end
    assign uf_val = hold;
`else
    assign uf_val = '0;
`endif
  end

  assign level0 = g_port[0].lvl;
  assign level1 = g_port[1].lvl;

  always_comb begin
    if (req_in[0])      io_in = g_port[0].rd_val;
    else if (req_in[1]) io_in = g_port[1].rd_val;
    else                io_in = last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= '0;
      underflow <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      if (|req_in) last_q <= io_in;
      // an event in the clr cycle wins over the clear
      underflow <= (underflow & ~clr) | uf_ev;
      req_err   <= (req_err & ~clr) | re_ev;
    end
  end

endmodule

// File: tb/tb_ssf_in_feeder.sv
// Randomized bench for ssf_in_feeder against a queue-based reference model.
// Builds with or without SSF_FEED_HOLD_EN; the model follows the same macro.
module tb_ssf_in_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_port = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  req_in = '0;
  logic [31:0] io_in;
  logic [4:0]  level0;
  logic [4:0]  level1;
  logic        underflow;
  logic        req_err;
  logic        clr = 1'b0;

  ssf_in_feeder #(.NUBITS(32), .DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_port    (s_port),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .req_in    (req_in),
    .io_in     (io_in),
    .level0    (level0),
    .level1    (level1),
    .underflow (underflow),
    .req_err   (req_err),
    .clr       (clr)
  );

  always #5 clk = ~clk;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] hold0 = '0;
  logic [31:0] hold1 = '0;
  logic [31:0] last = '0;
  logic        m_uf = 1'b0;
  logic        m_re = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  function automatic int qsize(input bit p);
    return p ? q1.size() : q0.size();
  endfunction

  function automatic logic [31:0] uf_value(input bit p);
`ifdef SSF_FEED_HOLD_EN
    return p ? hold1 : hold0;
`else
    return 32'h0;
`endif
  endfunction

  // expected io_in for a given strobe, from the model state
  function automatic logic [31:0] exp_io(input logic [1:0] r);
    bit p;
    if (r == 2'b00) return last;
    p = !r[0];
    if (qsize(p) == 0) return uf_value(p);
    return p ? q1[0] : q0[0];
  endfunction

  task automatic cyc(input logic v, input logic p,
                     input logic [31:0] d,
                     input logic [1:0] r,
                     input logic c);
    bit          pp;
    bit          do_push;
    logic [31:0] val;
    logic        ufev;
    @(negedge clk);
    s_valid = v;
    s_port  = p;
    s_data  = d;
    req_in  = r;
    clr     = c;
    #1;
    chk("s_ready", 64'(s_ready), 64'(qsize(p) != 16));
    chk("io_in", 64'(io_in), 64'(exp_io(r)));
    chk("level0", 64'(level0), 64'(q0.size()));
    chk("level1", 64'(level1), 64'(q1.size()));
    chk("underflow", 64'(underflow), 64'(m_uf));
    chk("req_err", 64'(req_err), 64'(m_re));
    do_push = v && (qsize(p) < 16);
    ufev = 1'b0;
    if (r != 2'b00) begin
      pp = !r[0];
      if (qsize(pp) > 0) begin
        if (pp) begin
          val = q1.pop_front();
          hold1 = val;
        end else begin
          val = q0.pop_front();
          hold0 = val;
        end
      end else begin
        val  = uf_value(pp);
        ufev = 1'b1;
      end
      last = val;
    end
    if (do_push) begin
      if (p) q1.push_back(d);
      else   q0.push_back(d);
    end
    m_uf = (m_uf && !c) || ufev;
    m_re = (m_re && !c) || (r == 2'b11);
    @(posedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic push(input logic p, input logic [31:0] d);
    cyc(1'b1, p, d, 2'b00, 1'b0);
  endtask

  task automatic pop(input logic [1:0] r);
    cyc(1'b0, 1'b0, 32'h0, r, 1'b0);
  endtask

  // async reset asserted between edges, checked before any clock
  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0;
    req_in  = 2'b00;
    clr     = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_level0", 64'(level0), 64'd0);
    chk("rst_level1", 64'(level1), 64'd0);
    chk("rst_io_in", 64'(io_in), 64'd0);
    chk("rst_uf", 64'(underflow), 64'd0);
    chk("rst_re", 64'(req_err), 64'd0);
    q0.delete();
    q1.delete();
    hold0 = '0;
    hold1 = '0;
    last  = '0;
    m_uf  = 1'b0;
    m_re  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int r;
    logic [1:0] rq;
    #3;
    chk("init_level0", 64'(level0), 64'd0);
    chk("init_io_in", 64'(io_in), 64'd0);
    chk("init_uf", 64'(underflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ordered read
    push(1'b0, 32'h11);
    push(1'b0, 32'h22);
    push(1'b0, 32'h33);
    repeat (3) pop(2'b01);
    idle();

    // fill port 1, 17th word dropped, one pop frees a slot
    for (int i = 0; i < 17; i++) push(1'b1, $urandom);
    pop(2'b10);
    cyc(1'b0, 1'b1, 32'h0, 2'b00, 1'b0);
    repeat (15) pop(2'b10);
    idle();

    // underflow after last pop of 0x7FFFFFFF
    push(1'b0, 32'h7FFF_FFFF);
    pop(2'b01);
    pop(2'b01);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    idle();

    // same-port push+pop at level 4
    for (int i = 0; i < 4; i++) push(1'b0, $urandom);
    cyc(1'b1, 1'b0, 32'hABCD_0001, 2'b01, 1'b0);
    idle();

    // illegal strobe with both ports non-empty
    push(1'b1, 32'h5555_0001);
    push(1'b1, 32'h5555_0002);
    pop(2'b11);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);

    // drain port 0 then push+pop on empty
    repeat (4) pop(2'b01);
    cyc(1'b1, 1'b0, 32'hBEEF_0001, 2'b01, 1'b0);
    idle();
    pop(2'b01);

    // wrap: 40 words streamed through port 0
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b0, 32'h1000 + i, 2'b01, 1'b0);
    pop(2'b01);

    // mid-stream reset with level0=5 and both flags set
    pop(2'b10);
    pop(2'b10);
    for (int i = 0; i < 6; i++) push(1'b0, $urandom);
    push(1'b1, 32'h77);
    pop(2'b11);
    idle();
    do_reset();
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rq = 2'b00;
      else if (r < 7) rq = 2'b01;
      else if (r < 9) rq = 2'b10;
      else            rq = 2'b11;
      cyc($urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)),
          $urandom, rq,
          $urandom_range(0, 15) == 0);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
